// File: rtl/rec_ser_par_if.sv
// Serial-receiver bus: the serial line in, and the received words and status out.
interface rec_ser_par_if #(
  parameter int WORD_W = 4
);
  logic              S;
  logic [WORD_W-1:0] A;
  logic [WORD_W-1:0] B;
  logic [WORD_W-1:0] C;
  logic [WORD_W-1:0] D;
  logic              valid;
  logic              busy;
  logic              frame_err;

  modport master (output S, input A, B, C, D, valid, busy, frame_err);
  modport slave  (input S, output A, B, C, D, valid, busy, frame_err);
endinterface

// File: rtl/rec_ser_par.sv
// Serial-to-parallel receiver: start bit, four MSB-first words, stop bit.
// Optional even-parity bit before the stop bit when RX_PARITY_EN is defined.
module rec_ser_par #(
  parameter int WORD_W = 4
) (
  input  logic         clock,
  input  logic         clr,
  rec_ser_par_if.slave bus
);
  localparam int FRAME_W = 4 * WORD_W;
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
`ifdef RX_PARITY_EN
    PARITY,
`endif
    STOP,
    RESYNC
  } state_t;

  state_t               state, state_nxt;
  logic [BW-1:0]        bit_cnt;
  logic [1:0]           word_cnt;
  logic [FRAME_W-1:0]   sreg;
  logic [WORD_W-1:0]    a_q, b_q, c_q, d_q;
  logic                 valid_q, err_q;
  logic                 start, shift, load, err, last_bit, par_err;

  assign last_bit = (bit_cnt == BIT_LAST) && (word_cnt == 2'd3);

`ifdef RX_PARITY_EN
  logic par_q;
  // Even parity: the data bits plus the parity bit must hold an even count of ones.
  assign par_err = (^sreg) ^ par_q;
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift     = 1'b0;
    load      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.S) begin
          start     = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        shift = 1'b1;
        if (last_bit) begin
`ifdef RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef RX_PARITY_EN
      PARITY: state_nxt = STOP;
`endif
      STOP: begin
        if (bus.S && !par_err) begin
          load      = 1'b1;
          state_nxt = IDLE;
        end else begin
          // A low stop bit leaves the line mid-frame; wait for it to idle high.
          err       = 1'b1;
          state_nxt = bus.S ? IDLE : RESYNC;
        end
      end
      RESYNC: begin
        if (bus.S) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
      sreg     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef RX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      valid_q <= load;
      err_q   <= err;
      if (start) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
      end
      if (shift) begin
        sreg <= {sreg[FRAME_W-2:0], bus.S};
        if (bit_cnt == BIT_LAST) begin
          bit_cnt  <= '0;
          word_cnt <= word_cnt + 2'd1;
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
`ifdef RX_PARITY_EN
      if (state == PARITY) par_q <= bus.S;
`endif
      if (load) begin
        a_q <= sreg[FRAME_W-1 -: WORD_W];
        b_q <= sreg[3*WORD_W-1 -: WORD_W];
        c_q <= sreg[2*WORD_W-1 -: WORD_W];
        d_q <= sreg[WORD_W-1:0];
      end
    end
  end

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.C         = c_q;
  assign bus.D         = d_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state != IDLE);
endmodule
